// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the data-bus access controller: bus request/response
// structs, the 64-bit data word and the controller state encoding.
package mem_access_ctrl_pkg;

   typedef logic [63:0] word_t;
   typedef logic [31:0] addr_t;
   typedef logic [7:0]  strobe_t;

   typedef struct packed {
      logic    valid;
      addr_t   addr;
      strobe_t strobe;
      word_t   data;
   } dbus_req_t;

   typedef struct packed {
      logic  addr_ok;
      logic  data_ok;
      word_t data;
   } dbus_resp_t;

   typedef enum logic [1:0] {IDLE, BUSY, HOLD} mem_state_t;

endpackage

// File: rtl/mem_access_ctrl_timeout.sv
// Bus-timeout counter for mem_access_ctrl; only instantiated when
// MEM_ACCESS_TIMEOUT_EN is defined.
module mem_timeout_counter #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic resetn,
   input  logic enable_i,
   input  logic clear_i,
   output logic expired_o
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)
         cnt_d = '0;
      else if (enable_i)
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   // Fires during the TIMEOUT_CYCLES-th waiting cycle so the exit edge ends it.
   assign expired_o = enable_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Registers the memory-stage data-bus request, holds it until data_ok and
// stalls the pipeline meanwhile. Optional bus timeout: MEM_ACCESS_TIMEOUT_EN.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic       clk,
   input  logic       resetn,
   input  dbus_req_t  req_i,
   input  logic       flush_i,
   input  logic       advance_i,
   output dbus_req_t  dreq_o,
   input  dbus_resp_t dresp_i,
   output logic       stall_o,
   output logic       done_o,
   output word_t      rdata_o,
   output logic       timeout_o
);

   mem_state_t state_q, state_d;
   dbus_req_t  req_q;
   word_t      rdata_q;
   logic       killed_q;
   logic       expired;
   logic       finish;
   logic       accept;

   assign accept = (state_q == IDLE) && req_i.valid && !flush_i;
   assign finish = (state_q == BUSY) && (dresp_i.data_ok || expired);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept) state_d = BUSY;
         // A flush arriving with completion counts as a kill.
         BUSY: if (finish) state_d = (killed_q || flush_i) ? IDLE : HOLD;
         HOLD: if (advance_i || flush_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      dreq_o = '0;
      done_o = 1'b0;
      unique case (state_q)
         BUSY: begin
            dreq_o       = req_q;
            dreq_o.valid = 1'b1;
         end
         HOLD:    done_o = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         req_q    <= '0;
         rdata_q  <= '0;
         killed_q <= 1'b0;
      end else begin
         if (accept) begin
            req_q    <= req_i;
            killed_q <= 1'b0;
         end else if ((state_q == BUSY) && flush_i) begin
            killed_q <= 1'b1;
         end
         if ((state_q == BUSY) && dresp_i.data_ok)
            rdata_q <= (|req_q.strobe) ? '0 : dresp_i.data;
         else if (expired)
            rdata_q <= '0;
      end
   end

   assign stall_o = req_i.valid && !flush_i && (state_q != HOLD);
   assign rdata_o = rdata_q;

`ifdef MEM_ACCESS_TIMEOUT_EN
   logic timeout_q;
   logic unused_ok;

   mem_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk       (clk),
      .resetn    (resetn),
      .enable_i  ((state_q == BUSY) && !dresp_i.data_ok),
      .clear_i   (state_q != BUSY),
      .expired_o (expired)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         timeout_q <= 1'b0;
      else if (expired)
         timeout_q <= 1'b1;
   end

   assign timeout_o = timeout_q;
   assign unused_ok = dresp_i.addr_ok ^ req_q.valid;
`else
   logic unused_ok;

   assign expired   = 1'b0;
   assign timeout_o = 1'b0;
   assign unused_ok = dresp_i.addr_ok ^ req_q.valid ^ (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed accesses push expected
// completions; a monitor checks each done_o rising edge against the queue.
module tb_mem_access_ctrl;
   import mem_access_ctrl_pkg::*;

   typedef struct {
      word_t rdata;
      logic  tmo;
   } exp_t;

   logic       clk = 1'b0;
   logic       resetn;
   dbus_req_t  req;
   logic       flush;
   logic       advance;
   dbus_req_t  dreq;
   dbus_resp_t resp;
   logic       stall;
   logic       done;
   word_t      rdata;
   logic       timeout;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];
   exp_t mon_e;
   logic done_prev = 1'b0;
   logic tmo_exp = 1'b0;

   mem_access_ctrl #(
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .req_i     (req),
      .flush_i   (flush),
      .advance_i (advance),
      .dreq_o    (dreq),
      .dresp_i   (resp),
      .stall_o   (stall),
      .done_o    (done),
      .rdata_o   (rdata),
      .timeout_o (timeout)
   );

   always #5 clk = ~clk;

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %b required %b", nm, act, exp);
      end
   endtask

   task automatic chk64(input string nm, input word_t act, input word_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %h required %h", nm, act, exp);
      end
   endtask

   task automatic chkreq(input string nm, input dbus_req_t act, input dbus_req_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %h required %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_cyc(input string nm, input logic st, input logic vl, input logic dn);
      @(negedge clk);
      chk1({nm, ".stall"}, stall, st);
      chk1({nm, ".valid"}, dreq.valid, vl);
      chk1({nm, ".done"}, done, dn);
   endtask

   task automatic set_req(input logic v, input addr_t a, input strobe_t s, input word_t d);
      req.valid  = v;
      req.addr   = a;
      req.strobe = s;
      req.data   = d;
   endtask

   task automatic set_resp(input logic ok, input word_t d);
      resp.addr_ok = ok;
      resp.data_ok = ok;
      resp.data    = d;
   endtask

   // Two-cycle load with data_ok in the first BUSY cycle.
   task automatic quick_load(input string nm, input addr_t a, input word_t d);
      tick();
      set_req(1'b1, a, 8'h00, 64'h0);
      expect_cyc({nm, "0"}, 1'b1, 1'b0, 1'b0);
      tick();
      sb.push_back('{d, tmo_exp});
      set_resp(1'b1, d);
      expect_cyc({nm, "1"}, 1'b1, 1'b1, 1'b0);
      chk64({nm, "1.addr"}, 64'(dreq.addr), 64'(a));
      tick();
      set_resp(1'b0, 64'h0);
      advance = 1'b1;
      expect_cyc({nm, "2"}, 1'b0, 1'b0, 1'b1);
      chk64({nm, "2.rdata"}, rdata, d);
      tick();
      advance = 1'b0;
      set_req(1'b0, 32'h0, 8'h00, 64'h0);
      expect_cyc({nm, "3"}, 1'b0, 1'b0, 1'b0);
   endtask

   always @(negedge clk) begin
      if (!resetn) begin
         done_prev = 1'b0;
      end else begin
         if (done && !done_prev) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL mon_unexpected_done: actual done_o=1 required no completion");
            end else begin
               mon_e = sb.pop_front();
               chk64("mon_rdata", rdata, mon_e.rdata);
               chk1("mon_timeout", timeout, mon_e.tmo);
            end
         end
         done_prev = done;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual no finish required finish before 200000");
      $fatal(1);
   end

   initial begin
      dbus_req_t st_exp;
      dbus_req_t fl_exp;

      resetn  = 1'b0;
      flush   = 1'b0;
      advance = 1'b0;
      set_req(1'b1, 32'h0, 8'h00, 64'h0);
      set_resp(1'b0, 64'h0);
      #3;
      chk1("rst.stall", stall, 1'b1);
      chkreq("rst.dreq", dreq, '0);
      chk1("rst.done", done, 1'b0);
      chk64("rst.rdata", rdata, 64'h0);
      chk1("rst.timeout", timeout, 1'b0);
      req.valid = 1'b0;
      #9;
      resetn = 1'b1;

      // Load
      quick_load("ld", 32'h8000_0010, 64'hDEADBEEF00000001);

      // Store with three wait cycles, then HOLD backpressure
      st_exp = '{valid: 1'b1, addr: 32'h8000_0020, strobe: 8'hFF, data: 64'h1234};
      tick();
      set_req(1'b1, 32'h8000_0020, 8'hFF, 64'h1234);
      expect_cyc("st0", 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         if (i == 4) begin
            sb.push_back('{64'h0, tmo_exp});
            set_resp(1'b1, 64'hCAFE);
         end
         expect_cyc($sformatf("st%0d", i), 1'b1, 1'b1, 1'b0);
         chkreq($sformatf("st%0d.req", i), dreq, st_exp);
      end
      for (int i = 5; i <= 8; i++) begin
         tick();
         set_resp(1'b0, 64'h0);
         advance = (i == 8);
         expect_cyc($sformatf("hold%0d", i), 1'b0, 1'b0, 1'b1);
         chk64($sformatf("hold%0d.rdata", i), rdata, 64'h0);
      end
      tick();
      advance = 1'b0;
      set_req(1'b0, 32'h0, 8'h00, 64'h0);
      expect_cyc("hold9", 1'b0, 1'b0, 1'b0);

      // Flush in second BUSY cycle; next request latched after the kill
      fl_exp = '{valid: 1'b1, addr: 32'h8000_0030, strobe: 8'h00, data: 64'h0};
      tick();
      set_req(1'b1, 32'h8000_0030, 8'h00, 64'h0);
      expect_cyc("f0", 1'b1, 1'b0, 1'b0);
      tick();
      expect_cyc("f1", 1'b1, 1'b1, 1'b0);
      tick();
      flush = 1'b1;
      expect_cyc("f2", 1'b0, 1'b1, 1'b0);
      chkreq("f2.req", dreq, fl_exp);
      tick();
      flush = 1'b0;
      set_req(1'b1, 32'h8000_0040, 8'h00, 64'h0);
      expect_cyc("f3", 1'b1, 1'b1, 1'b0);
      chkreq("f3.req", dreq, fl_exp);
      tick();
      set_resp(1'b1, 64'hAAAA);
      expect_cyc("f4", 1'b1, 1'b1, 1'b0);
      chkreq("f4.req", dreq, fl_exp);
      tick();
      set_resp(1'b0, 64'h0);
      expect_cyc("f5", 1'b1, 1'b0, 1'b0);
      tick();
      sb.push_back('{64'h5555, tmo_exp});
      set_resp(1'b1, 64'h5555);
      expect_cyc("f6", 1'b1, 1'b1, 1'b0);
      chk64("f6.addr", 64'(dreq.addr), 64'h8000_0040);
      tick();
      set_resp(1'b0, 64'h0);
      advance = 1'b1;
      expect_cyc("f7", 1'b0, 1'b0, 1'b1);
      tick();
      advance = 1'b0;
      set_req(1'b0, 32'h0, 8'h00, 64'h0);
      expect_cyc("f8", 1'b0, 1'b0, 1'b0);

      // Reset pulsed mid-BUSY
      tick();
      set_req(1'b1, 32'h8000_0050, 8'h00, 64'h0);
      expect_cyc("r0", 1'b1, 1'b0, 1'b0);
      tick();
      expect_cyc("r1", 1'b1, 1'b1, 1'b0);
      #2;
      resetn = 1'b0;
      #1;
      chk1("r.async_valid", dreq.valid, 1'b0);
      chk64("r.async_rdata", rdata, 64'h0);
      set_req(1'b0, 32'h0, 8'h00, 64'h0);
      tick();
      resetn = 1'b1;
      expect_cyc("r2", 1'b0, 1'b0, 1'b0);
      chk64("r2.rdata", rdata, 64'h0);
      quick_load("rl", 32'h8000_0058, 64'h0123456789ABCDEF);

`ifdef MEM_ACCESS_TIMEOUT_EN
      tick();
      set_req(1'b1, 32'h8000_0060, 8'h00, 64'h0);
      expect_cyc("t0", 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (i == 8) sb.push_back('{64'h0, 1'b1});
         expect_cyc($sformatf("t%0d", i), 1'b1, 1'b1, 1'b0);
         chk1($sformatf("t%0d.timeout", i), timeout, 1'b0);
      end
      tick();
      advance = 1'b1;
      expect_cyc("t9", 1'b0, 1'b0, 1'b1);
      chk1("t9.timeout", timeout, 1'b1);
      chk64("t9.rdata", rdata, 64'h0);
      tick();
      advance = 1'b0;
      set_req(1'b0, 32'h0, 8'h00, 64'h0);
      expect_cyc("t10", 1'b0, 1'b0, 1'b0);
      tmo_exp = 1'b1;
      quick_load("tl", 32'h8000_0068, 64'h77);
      chk1("tl.timeout_sticky", timeout, 1'b1);
`else
      chk1("no_timeout", timeout, 1'b0);
`endif

      tick();
      tick();
      while (sb.size() != 0) begin
         mon_e = sb.pop_front();
         n_cmp++;
         n_err++;
         $display("FAIL mon_missing_done: actual no completion required rdata %h", mon_e.rdata);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
